// File: rtl/conv_window_gen.sv
// -----------------------------------------------------------------------------
// conv_window_gen
//
// K x K sliding-window generator for the PE convolution datapath.
// It keeps a shift history of the raster pixel stream, (K-1) full lines plus
// K pixels. It presents the K x K data window next to a K x K weight window.
// The weight window is loaded through a daisy chain shared with neighbouring
// PEs.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   d_in       pixel data (N bits)
//   en_in      pixel accept strobe, one pixel per high cycle
//   sof        start of frame; only honoured together with en_in
//   w_in       weight chain input (M bits)
//   w_conf     weight shift enable
//   w_out      weight chain output towards the next PE
//   w_ready    K*K weights loaded by the current w_conf burst
//   win_valid  one-cycle pulse: d_grp holds a window that lies within one line
//   d_grp      data window; tap (r,c) = pixel of age r*LINES+c, tap (0,0) in MSBs
//   w_grp      weight window; weight tap 0 in MSBs
// -----------------------------------------------------------------------------
module conv_window_gen #(
   parameter int K     = 3,
   parameter int LINES = 16,
   parameter int N     = 4,
   parameter int M     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     d_in,
   input  logic             en_in,
   input  logic             sof,
   input  logic [M-1:0]     w_in,
   input  logic             w_conf,
   output logic [M-1:0]     w_out,
   output logic             w_ready,
   output logic             win_valid,
   output logic [K*K*N-1:0] d_grp,
   output logic [K*K*M-1:0] w_grp
);

   localparam int KK    = K * K;
   localparam int DEPTH = (K - 1) * LINES + K;
   localparam int CW    = (LINES > 1) ? $clog2(LINES) : 1;
   localparam int RW    = $clog2(K);
   localparam int WCW   = $clog2(KK + 1);

   localparam logic [CW-1:0]  COL_LAST  = CW'(LINES - 1);
   localparam logic [CW-1:0]  COL_MIN   = CW'(K - 1);
   localparam logic [RW-1:0]  ROW_LAST  = RW'(K - 1);
   localparam logic [WCW-1:0] WCNT_FULL = WCW'(KK);

   // Pixel history: hist_p0[a] holds the pixel of age a.
   logic [N-1:0]   hist_p0 [DEPTH];
   logic [M-1:0]   wtap_p0 [KK];

   // col/row hold the position the next accepted pixel will take.
   logic [CW-1:0]  col, col_eff, col_nxt;
   logic [RW-1:0]  row, row_eff, row_nxt;
   logic           hit;
   logic [WCW-1:0] w_cnt, w_cnt_nxt;
   logic           w_conf_q;

   // Position bookkeeping for the pixel presented this cycle.
   always_comb begin
      col_eff = sof ? '0 : col;
      row_eff = sof ? '0 : row;
      // Requiring col >= K-1 suppresses windows that straddle a line wrap.
      hit     = (row_eff >= ROW_LAST) && (col_eff >= COL_MIN);
      col_nxt = col_eff + 1'b1;
      row_nxt = row_eff;
      if (col_eff == COL_LAST) begin
         col_nxt = '0;
         if (row_eff != ROW_LAST) begin
            row_nxt = row_eff + 1'b1;
         end
      end
   end

   // A burst count restarts at 1 on the first cycle of every new w_conf burst.
   always_comb begin
      w_cnt_nxt = w_cnt;
      if (w_conf) begin
         if (!w_conf_q) begin
            w_cnt_nxt = WCW'(1);
         end else if (w_cnt != WCNT_FULL) begin
            w_cnt_nxt = w_cnt + 1'b1;
         end
      end
   end

   // ---- stage p0: pixel history and position counters ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            hist_p0[i] <= '0;
         end
         col       <= '0;
         row       <= '0;
         win_valid <= 1'b0;
      end else begin
         win_valid <= en_in & hit;
         if (en_in) begin
            hist_p0[0] <= d_in;
            for (int i = 1; i < DEPTH; i++) begin
               hist_p0[i] <= hist_p0[i-1];
            end
            col <= col_nxt;
            row <= row_nxt;
         end
      end
   end

   // ---- stage p0: weight chain and load status ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j < KK; j++) begin
            wtap_p0[j] <= '0;
         end
         w_out    <= '0;
         w_cnt    <= '0;
         w_conf_q <= 1'b0;
         w_ready  <= 1'b0;
      end else begin
         w_conf_q <= w_conf;
         w_cnt    <= w_cnt_nxt;
         w_ready  <= (w_cnt_nxt == WCNT_FULL);
         if (w_conf) begin
            wtap_p0[0] <= w_in;
            for (int j = 1; j < KK; j++) begin
               wtap_p0[j] <= wtap_p0[j-1];
            end
            w_out <= wtap_p0[KK-1];
         end
      end
   end

   // Window taps are fixed slices of the history; tap (0,0) lands in the MSBs.
   for (genvar r = 0; r < K; r++) begin : g_row
      for (genvar c = 0; c < K; c++) begin : g_col
         assign d_grp[(KK-1-(r*K+c))*N +: N] = hist_p0[r*LINES+c];
      end
   end

   for (genvar j = 0; j < KK; j++) begin : g_wtap
      assign w_grp[(KK-1-j)*M +: M] = wtap_p0[j];
   end

endmodule

// File: tb/tb_conv_window_gen.sv
module tb_conv_window_gen;

   localparam int K     = 3;
   localparam int LINES = 8;
   localparam int N     = 4;
   localparam int M     = 4;
   localparam int KK    = K * K;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     d_in;
   logic             en_in;
   logic             sof;
   logic [M-1:0]     w_in;
   logic             w_conf;
   logic [M-1:0]     w_out;
   logic             w_ready;
   logic             win_valid;
   logic [KK*N-1:0]  d_grp;
   logic [KK*M-1:0]  w_grp;

   always #5 clk = ~clk;

   conv_window_gen #(.K(K), .LINES(LINES), .N(N), .M(M)) dut (
      .clk(clk), .rst(rst), .d_in(d_in), .en_in(en_in), .sof(sof),
      .w_in(w_in), .w_conf(w_conf), .w_out(w_out), .w_ready(w_ready),
      .win_valid(win_valid), .d_grp(d_grp), .w_grp(w_grp)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: plain history of everything accepted since reset,
   // pixel index within the current frame, shifted weights, burst length.
   logic [N-1:0] pq[$];
   logic [M-1:0] wq[$];
   int           fidx;
   int           wrun;
   logic         wprev;

   typedef struct {
      logic            wc;
      logic [M-1:0]    wi;
      logic            rdy;
      logic [M-1:0]    wo;
      logic [KK*M-1:0] wg;
   } wvec_t;
   wvec_t wt[12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
      end
   endtask

   function automatic logic [KK*N-1:0] model_dgrp();
      logic [KK*N-1:0] v;
      int age;
      v = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K; c++) begin
            age = r * LINES + c;
            if (age < pq.size()) v[(KK-1-(r*K+c))*N +: N] = pq[pq.size()-1-age];
         end
      end
      return v;
   endfunction

   function automatic logic [KK*M-1:0] model_wgrp();
      logic [KK*M-1:0] v;
      v = '0;
      for (int j = 0; j < KK; j++) begin
         if (j < wq.size()) v[(KK-1-j)*M +: M] = wq[wq.size()-1-j];
      end
      return v;
   endfunction

   function automatic logic [M-1:0] model_wout();
      if (wq.size() > KK) return wq[wq.size()-1-KK];
      return '0;
   endfunction

   task automatic model_clear();
      pq.delete();
      wq.delete();
      fidx  = 0;
      wrun  = 0;
      wprev = 1'b0;
   endtask

   // One clock cycle with the given inputs; model updated and all outputs checked.
   task automatic cycle(input logic en, input logic s, input logic [N-1:0] d,
                        input logic wc, input logic [M-1:0] wi, output logic vld);
      logic ev;
      en_in = en; sof = s; d_in = d; w_conf = wc; w_in = wi;
      @(posedge clk);
      #1;
      ev = 1'b0;
      if (en) begin
         if (s) fidx = 0;
         ev = ((fidx / LINES) >= K - 1) && ((fidx % LINES) >= K - 1);
         pq.push_back(d);
         if (pq.size() > 64) void'(pq.pop_front());
         fidx++;
      end
      if (wc) begin
         wrun = wprev ? ((wrun < KK) ? wrun + 1 : KK) : 1;
         wq.push_back(wi);
         if (wq.size() > 64) void'(wq.pop_front());
      end
      wprev = wc;
      check("win_valid", win_valid, ev);
      check("d_grp", d_grp, model_dgrp());
      check("w_grp", w_grp, model_wgrp());
      check("w_out", w_out, model_wout());
      check("w_ready", w_ready, wrun == KK);
      vld = win_valid;
   endtask

   task automatic apply_reset();
      en_in = 0; sof = 0; d_in = 0; w_conf = 0; w_in = 0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic v;
      int first, pulses, col01, idx, budget;

      wt[0]  = '{1'b1, 4'h1, 1'b0, 4'h0, 36'h100000000};
      wt[1]  = '{1'b1, 4'h2, 1'b0, 4'h0, 36'h210000000};
      wt[2]  = '{1'b1, 4'h3, 1'b0, 4'h0, 36'h321000000};
      wt[3]  = '{1'b1, 4'h4, 1'b0, 4'h0, 36'h432100000};
      wt[4]  = '{1'b1, 4'h5, 1'b0, 4'h0, 36'h543210000};
      wt[5]  = '{1'b1, 4'h6, 1'b0, 4'h0, 36'h654321000};
      wt[6]  = '{1'b1, 4'h7, 1'b0, 4'h0, 36'h765432100};
      wt[7]  = '{1'b1, 4'h8, 1'b0, 4'h0, 36'h876543210};
      wt[8]  = '{1'b1, 4'h9, 1'b1, 4'h0, 36'h987654321};
      wt[9]  = '{1'b1, 4'hA, 1'b1, 4'h1, 36'hA98765432};
      wt[10] = '{1'b0, 4'h0, 1'b1, 4'h1, 36'hA98765432};
      wt[11] = '{1'b1, 4'hB, 1'b0, 4'h2, 36'hBA9876543};

      // Reset state
      apply_reset();
      check("rst_d_grp", d_grp, 0);
      check("rst_w_grp", w_grp, 0);
      check("rst_w_out", w_out, 0);
      check("rst_w_ready", w_ready, 0);
      check("rst_win_valid", win_valid, 0);

      // Five contiguous lines, d = index mod 16, sof on pixel 0
      first = -1; pulses = 0; col01 = 0;
      for (int p = 0; p < 40; p++) begin
         cycle(1'b1, p == 0, 4'(p % 16), 1'b0, 4'h0, v);
         if (v) begin
            pulses++;
            if (first < 0) first = p;
            if ((p % LINES) < 2) col01++;
         end
         if (p == 18) begin
            check("tap00", d_grp[8*N +: N], 2);
            check("tap02", d_grp[6*N +: N], 0);
            check("tap10", d_grp[5*N +: N], 10);
            check("tap20", d_grp[2*N +: N], 2);
            check("tap22", d_grp[0 +: N], 0);
         end
      end
      check("first_valid_idx", first, 18);
      check("pulses_5_lines", pulses, 18);
      check("pulses_col01", col01, 0);

      // Same stream with random en_in gaps
      apply_reset();
      idx = 0; pulses = 0; budget = 0;
      while (idx < 40 && budget < 400) begin
         if ($urandom_range(1, 0) == 1) begin
            cycle(1'b1, idx == 0, 4'(idx % 16), 1'b0, 4'h0, v);
            idx++;
         end else begin
            cycle(1'b0, 1'($urandom), 4'($urandom), 1'b0, 4'h0, v);
         end
         if (v) pulses++;
         budget++;
      end
      check("gap_stream_done", idx, 40);
      check("gap_pulses", pulses, 18);

      // sof restart on pixel 10
      apply_reset();
      first = -1;
      for (int p = 0; p < 40; p++) begin
         cycle(1'b1, p == 10, 4'($urandom), 1'b0, 4'h0, v);
         if (v && first < 0) first = p;
      end
      check("sof_first_valid", first, 28);

      // Weight chain table
      apply_reset();
      for (int i = 0; i < 12; i++) begin
         cycle(1'b0, 1'b0, 4'h0, wt[i].wc, wt[i].wi, v);
         check("wt_ready", w_ready, wt[i].rdy);
         check("wt_out", w_out, wt[i].wo);
         check("wt_grp", w_grp, wt[i].wg);
      end

      // Randomized mixed traffic
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom), ($urandom_range(29, 0) == 0), 4'($urandom),
               ($urandom_range(9, 0) < 7), 4'($urandom), v);
      end

      // Asynchronous reset mid-line with both paths active
      for (int p = 0; p < 12; p++) begin
         cycle(1'b1, 1'b0, 4'($urandom_range(15, 1)), 1'b1, 4'($urandom_range(15, 1)), v);
      end
      check("pre_rst_ready", w_ready, 1);
      en_in = 1'b1; w_conf = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      check("arst_d_grp", d_grp, 0);
      check("arst_w_grp", w_grp, 0);
      check("arst_w_out", w_out, 0);
      check("arst_w_ready", w_ready, 0);
      check("arst_win_valid", win_valid, 0);
      model_clear();
      @(posedge clk);
      #1;
      rst = 1'b0;
      first = -1;
      for (int p = 0; p < 24; p++) begin
         cycle(1'b1, 1'b0, 4'($urandom), 1'b0, 4'h0, v);
         if (v && first < 0) first = p + 1;
      end
      check("arst_first_valid_count", first, 19);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
